// File: rtl/mem_port_arbiter_if.sv
// Bundle between the IF/MEM stages, the arbiter and the unified memory.
// The arbiter takes the slave view; requesters and memory take the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 7
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_valid;
    logic              dm_read;
    logic              dm_write;
    logic [31:0]       dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;
    logic              dm_valid;
    logic              stall_if;
    logic              stall_mem;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              align_err;

    modport slave (
        input  if_req, if_addr,
        input  dm_read, dm_write, dm_addr, dm_wdata,
        input  mem_rdata, mem_ready,
        output if_rdata, if_valid,
        output dm_rdata, dm_valid,
        output stall_if, stall_mem,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output align_err
    );

    modport master (
        output if_req, if_addr,
        output dm_read, dm_write, dm_addr, dm_wdata,
        output mem_rdata, mem_ready,
        input  if_rdata, if_valid,
        input  dm_rdata, dm_valid,
        input  stall_if, stall_mem,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  align_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Data side wins by default; a starvation counter forces fetch through.
module mem_port_arbiter #(
    parameter int ADDR_W       = 7,
    parameter int STARVE_LIMIT = 4
) (
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        ACC_IF,
        ACC_DM,
        DONE_IF,
        DONE_DM
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       dm_rdata_q;
    logic              err_q;

    logic arb, if_eff, dm_eff, starved;
    logic grant_if, grant_dm, if_bad, dm_bad;
    logic unused_hi;

    assign unused_hi = ^{bus.if_addr[31:ADDR_W], bus.dm_addr[31:ADDR_W]};

    // The requester completing this cycle is masked so its held level
    // is not granted a second time.
    assign arb = (state_q == IDLE) || (state_q == DONE_IF)
              || (state_q == DONE_DM);
    assign if_eff  = bus.if_req & (state_q != DONE_IF);
    assign dm_eff  = (bus.dm_read | bus.dm_write) & (state_q != DONE_DM);
    assign starved = if_eff & (cnt_q == LIMIT);

    assign grant_if = arb & if_eff & (~dm_eff | starved);
    assign grant_dm = arb & dm_eff & ~grant_if;

    assign if_bad = bus.if_addr[1:0] != 2'b00;
    assign dm_bad = (bus.dm_addr[1:0] != 2'b00)
                  | (bus.dm_read & bus.dm_write);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE_IF, DONE_DM: begin
                if (grant_if)
                    state_d = if_bad ? DONE_IF : ACC_IF;
                else if (grant_dm)
                    state_d = dm_bad ? DONE_DM : ACC_DM;
                else
                    state_d = IDLE;
            end
            ACC_IF:
                if (bus.mem_ready) state_d = DONE_IF;
            ACC_DM:
                if (bus.mem_ready) state_d = DONE_DM;
            default:
                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_if) begin
                addr_q <= bus.if_addr[ADDR_W-1:0];
                we_q   <= 1'b0;
                if (if_bad) begin
                    if_rdata_q <= '0;
                    err_q      <= 1'b1;
                end
            end
            if (grant_dm) begin
                addr_q  <= bus.dm_addr[ADDR_W-1:0];
                wdata_q <= bus.dm_wdata;
                we_q    <= bus.dm_write;
                if (dm_bad) begin
                    dm_rdata_q <= '0;
                    err_q      <= 1'b1;
                end
            end
            if (state_q == ACC_IF && bus.mem_ready)
                if_rdata_q <= bus.mem_rdata;
            if (state_q == ACC_DM && bus.mem_ready)
                dm_rdata_q <= we_q ? 32'd0 : bus.mem_rdata;
            if (grant_if)
                cnt_q <= '0;
            else if (grant_dm) begin
                if (!if_eff)
                    cnt_q <= '0;
                else if (cnt_q != LIMIT)
                    cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.mem_req   = (state_q == ACC_IF) || (state_q == ACC_DM);
    assign bus.mem_we    = we_q & bus.mem_req;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_valid  = (state_q == DONE_IF);
    assign bus.dm_valid  = (state_q == DONE_DM);
    assign bus.align_err = err_q;
    assign bus.stall_if  = bus.if_req & ~bus.if_valid;
    assign bus.stall_mem = (bus.dm_read | bus.dm_write) & ~bus.dm_valid;
endmodule
